five_by_five_window: RTL
========================

Name: five_by_five_window

Overview:
Consumes the five recirculating line-buffer outputs plus the live pixel from the five-row line array. Reorders rows from oldest to newest using the array write-select. Shifts one column per accepted pixel into a 25-register 5x5 window and flags the window valid once five columns of the current row are loaded. Sits directly downstream of the line array and feeds the feature-detection kernels.

Parameters:
- WIDTH, 420, pixels per image row; column counter wraps at WIDTH-1.
- PIX_W, 8, pixel width in bits.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- din  in  PIX_W  live pixel, same value presented to the line array this cycle (newest row).
- row0..row4  in  PIX_W each  line array outputs dout0..dout4.
- asel  in  5  one-hot write select currently driving the line array.
- validin  in  1  line array validout; qualifies din/row*/asel.
- window  out  25*PIX_W  flattened window; element (r,c) at bits [(r*5+c)*PIX_W +: PIX_W]; r=0 top/oldest, c=0 left/oldest.
- win_valid  out  1  window holds 5 complete columns ending at the most recent accepted pixel.
- sel_err  out  1  sticky: validin seen with asel not one-hot.

Behaviour:
- Reset (reset low, async): all window registers 0, column counter 0, win_valid 0, sel_err 0. Reset mid-row discards partial data; the first accepted pixel after release is column 0.
- Row ordering: k is the index of the set asel bit.
  - Column vector top to bottom = row[(k+1)%5], row[(k+2)%5], row[(k+3)%5], row[(k+4)%5], din.
  - row[k] (the row being overwritten) is not used.
- Shift: on a rising edge with validin=1 and asel one-hot:
  - every window row shifts left one column (c <= c+1 contents);
  - the new column vector enters c=4.
- Hold: validin=0 leaves the window, counter and win_valid unchanged.
- Column counter col (0..WIDTH-1): increments per accepted pixel and wraps WIDTH-1 -> 0. Width is clog2(WIDTH).
- win_valid: registered; latency 1 cycle from the accepting edge.
  - On an accepting edge: win_valid <= (col >= 4), using col before increment.
  - Columns 0..3 of every row give win_valid=0, so a window never spans a row boundary.
  - win_valid does not drop on validin=0 cycles; downstream qualifies with its own sampling of win_valid.
- Bad select: validin=1 with asel zero or multi-hot.
  - Cycle is ignored: no shift, no count, win_valid unchanged.
  - sel_err sets and stays set until reset.
- Wrap: accepting col=WIDTH-1 produces win_valid=1 for the last window of the row. The next accepted pixel (col 0) produces win_valid=0.

Optional Feature:
- Macro: FIVE_BY_FIVE_WINDOW_COORD_EN.
- Defined:
  - Adds outputs cx (clog2(WIDTH) bits) and cy (16 bits), registered alongside win_valid.
  - cx = col-2, the centre column of the window just formed.
  - cy increments on each col wrap; window centre row = cy (counts rows since reset).
  - cy saturates at 16'hFFFF; both reset to 0.
- Undefined: no cx/cy ports, no row counter logic; all other behaviour identical.

Decomposition:
- Shared package holds:
  - PIX_W default;
  - WIN_DIM=5;
  - a function returning the one-hot index and a one-hot-valid flag;
  - the window element index helper (r*5+c).
- One natural sub-module, window_column_mux: combinational reorder of row0..row4/din by asel into the 5-entry column vector.
- The shift registers, counter and flags stay in the top.

Test Plan:
- Reset: hold reset low, drive validin=1 with random data -> window all 0, win_valid 0, sel_err 0. Release; first pixel is treated as col 0.
- Ordering: asel=5'b00100, row0..row4=10,11,12,13,14, din=99, one accepted pixel -> window column c=4 top to bottom = 13,14,10,11,99.
- Fill/latency: stream pixel values 1..8 on row 4 with asel fixed.
  - win_valid rises the cycle after the 5th accept.
  - Window row 4 = 1..5, then 2..6 on the next accept.
  - A validin=0 gap holds all outputs.
- Row wrap with WIDTH=8: stream 16 pixels -> win_valid high after cols 4..7 of each row, low after cols 0..3 of the second row, counter wraps without a stall.
- Bad select: validin=1 with asel=0 and asel=5'b00011 -> no shift, col unchanged, sel_err=1 and sticky. Reset mid-row then clears all state.
- With FIVE_BY_FIVE_WINDOW_COORD_EN, WIDTH=8, 3 rows streamed -> first valid window reports cx=2, cy=0. Last window of row 2 reports cx=5, cy=2.

Source files
------------

// File: rtl/five_by_five_window_pkg.sv
// Shared types and helpers for the 5x5 window block: window geometry,
// one-hot select decoding and flattened element indexing.
package five_by_five_window_pkg;

    localparam int unsigned PIX_W_DEF = 8;
    localparam int unsigned WIN_DIM   = 5;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
    } onehot_t;

    // Index of the single set bit plus a flag that exactly one bit was set.
    function automatic onehot_t onehot_decode(input logic [WIN_DIM-1:0] sel);
        onehot_t     res;
        int unsigned n;
        res = '0;
        n   = 0;
        for (int unsigned i = 0; i < WIN_DIM; i++) begin
            if (sel[i]) begin
                n++;
                res.idx = 3'(i);
            end
        end
        res.valid = (n == 1);
        return res;
    endfunction

    function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
        return r * WIN_DIM + c;
    endfunction

endpackage

// File: rtl/five_by_five_window_if.sv
// Line-array to window link: live pixel, five buffered rows, write select
// and the qualifying valid.
interface five_by_five_window_if #(
    parameter int unsigned PIX_W = 8
);
    logic [PIX_W-1:0] din;
    logic [PIX_W-1:0] row0;
    logic [PIX_W-1:0] row1;
    logic [PIX_W-1:0] row2;
    logic [PIX_W-1:0] row3;
    logic [PIX_W-1:0] row4;
    logic [4:0]       asel;
    logic             validin;

    modport master (output din, row0, row1, row2, row3, row4, asel, validin);
    modport slave  (input  din, row0, row1, row2, row3, row4, asel, validin);
endinterface

// File: rtl/five_by_five_window_column_mux.sv
// Reorders the line-array outputs oldest to newest using the write-select
// index; the row currently being overwritten is dropped and din goes last.
module window_column_mux
    import five_by_five_window_pkg::*;
#(
    parameter int unsigned PIX_W = PIX_W_DEF
) (
    input  logic [PIX_W-1:0]                row0,
    input  logic [PIX_W-1:0]                row1,
    input  logic [PIX_W-1:0]                row2,
    input  logic [PIX_W-1:0]                row3,
    input  logic [PIX_W-1:0]                row4,
    input  logic [PIX_W-1:0]                din,
    input  logic [2:0]                      k,
    output logic [WIN_DIM-1:0][PIX_W-1:0]   col_vec
);

    logic [PIX_W-1:0] rows [WIN_DIM];
    logic [3:0]       s;

    assign rows[0] = row0;
    assign rows[1] = row1;
    assign rows[2] = row2;
    assign rows[3] = row3;
    assign rows[4] = row4;

    always_comb begin
        col_vec = '0;
        s       = '0;
        for (int unsigned r = 0; r < WIN_DIM - 1; r++) begin
            // (k + r + 1) mod 5 without a divider
            s = {1'b0, k} + 4'(r) + 4'd1;
            if (s >= 4'(WIN_DIM)) s = s - 4'(WIN_DIM);
            col_vec[r] = rows[s[2:0]];
        end
        col_vec[WIN_DIM-1] = din;
    end

endmodule

// File: rtl/five_by_five_window.sv
// 5x5 sliding pixel window fed by the five-row line array.
// Optional FIVE_BY_FIVE_WINDOW_COORD_EN adds window-centre coordinates cx/cy.
module five_by_five_window
    import five_by_five_window_pkg::*;
#(
    parameter  int unsigned WIDTH = 420,
    parameter  int unsigned PIX_W = PIX_W_DEF,
    localparam int unsigned COL_W = $clog2(WIDTH)
) (
    input  logic                         clock,
    input  logic                         reset,
    five_by_five_window_if.slave         px,
    output logic [25*PIX_W-1:0]          window,
    output logic                         win_valid,
    output logic                         sel_err
`ifdef FIVE_BY_FIVE_WINDOW_COORD_EN
    ,
    output logic [COL_W-1:0]             cx,
    output logic [15:0]                  cy
`endif
);

    logic [WIN_DIM-1:0][WIN_DIM-1:0][PIX_W-1:0] win_q;
    logic [WIN_DIM-1:0][PIX_W-1:0]              col_vec;
    logic [COL_W-1:0]                           col;
    onehot_t                                    sel;
    logic                                       accept;
    logic                                       bad_sel;
    logic                                       col_wrap;

    assign sel      = onehot_decode(px.asel);
    assign accept   = px.validin &  sel.valid;
    assign bad_sel  = px.validin & ~sel.valid;
    assign col_wrap = (col == COL_W'(WIDTH - 1));

    // Packed [r][c] layout places element (r,c) at (r*5+c)*PIX_W.
    assign window = win_q;

    window_column_mux #(.PIX_W(PIX_W)) u_column_mux (
        .row0    (px.row0),
        .row1    (px.row1),
        .row2    (px.row2),
        .row3    (px.row3),
        .row4    (px.row4),
        .din     (px.din),
        .k       (sel.idx),
        .col_vec (col_vec)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            win_q     <= '0;
            col       <= '0;
            win_valid <= 1'b0;
            sel_err   <= 1'b0;
        end else begin
            if (bad_sel) sel_err <= 1'b1;
            if (accept) begin
                for (int unsigned r = 0; r < WIN_DIM; r++) begin
                    win_q[r] <= {col_vec[r], win_q[r][WIN_DIM-1:1]};
                end
                // Columns 0..3 never complete a window, so rows never blend
                win_valid <= (col >= COL_W'(WIN_DIM - 1));
                col       <= col_wrap ? '0 : col + 1'b1;
            end
        end
    end

`ifdef FIVE_BY_FIVE_WINDOW_COORD_EN
    logic [15:0] row_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            row_cnt <= '0;
            cx      <= '0;
            cy      <= '0;
        end else if (accept) begin
            cx <= col - COL_W'(2);
            cy <= row_cnt;
            if (col_wrap && row_cnt != '1) row_cnt <= row_cnt + 16'd1;
        end
    end
`endif

endmodule
